multdiv_seq: RTL and testbench

//   Sequential signed 32-bit multiply (radix-2 Booth) and, optionally, divide (non-restoring) unit.

---
 rtl/multdiv_seq.sv | 166 ++++++++++++++++
 tb/tb_multdiv_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - sequential signed Booth multiply / non-restoring divide unit
// Define MULTDIV_DIV_EN to build the divider; otherwise ctrl_DIV reports an exception immediately.

module addsub32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum
);
    assign sum = sub ? (a - b) : (a + b);
endmodule

module multdiv_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);
    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIX, S_DONE} state_t;

    state_t      state;
    logic [5:0]  count;
    logic [31:0] reg_a;
    logic [31:0] reg_q;
    logic [31:0] reg_m;
    logic        q_1;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_sub;
    logic [31:0] sum;
    logic        sum_sign;
    logic [31:0] mul_a;
    logic [31:0] mul_q;
`ifdef MULTDIV_DIV_EN
    logic        neg_q;
    logic        div_zero;
    logic        div_ovf;
`endif

    addsub32 u_addsub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (sum)
    );

    always_comb begin
        add_a   = reg_a;
        add_b   = 32'd0;
        add_sub = 1'b0;
        case (state)
            S_MULT: begin
                add_b   = (reg_q[0] ^ q_1) ? reg_m : 32'd0;
                add_sub = reg_q[0] & ~q_1;
            end
`ifdef MULTDIV_DIV_EN
            S_DIV: begin
                add_a   = {reg_a[30:0], reg_q[31]};
                add_b   = reg_m;
                add_sub = ~reg_a[31];
            end
            S_FIX: begin
                add_a   = 32'd0;
                add_b   = reg_q;
                add_sub = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Sign of the exact 33-bit sum, so A - 0x80000000 still shifts in the right sign bit.
    assign sum_sign = sum[31] ^ ((add_a[31] == (add_b[31] ^ add_sub)) && (sum[31] != add_a[31]));
    assign mul_a    = {sum_sign, sum[31:1]};
    assign mul_q    = {sum[0], reg_q[31:1]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            count          <= 6'd0;
            reg_a          <= 32'd0;
            reg_q          <= 32'd0;
            reg_m          <= 32'd0;
            q_1            <= 1'b0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef MULTDIV_DIV_EN
            neg_q          <= 1'b0;
            div_zero       <= 1'b0;
            div_ovf        <= 1'b0;
`endif
        end else if (ctrl_MULT) begin
            state          <= S_MULT;
            count          <= 6'd0;
            reg_a          <= 32'd0;
            reg_q          <= data_operandB;
            reg_m          <= data_operandA;
            q_1            <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
        end else if (ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
            state          <= S_DIV;
            count          <= 6'd0;
            reg_a          <= 32'd0;
            reg_q          <= data_operandA[31] ? -data_operandA : data_operandA;
            reg_m          <= data_operandB[31] ? -data_operandB : data_operandB;
            neg_q          <= data_operandA[31] ^ data_operandB[31];
            div_zero       <= (data_operandB == 32'd0);
            div_ovf        <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
            data_resultRDY <= 1'b0;
            busy           <= 1'b1;
`else
            state          <= S_DONE;
            data_result    <= 32'd0;
            data_exception <= 1'b1;
            data_resultRDY <= 1'b1;
            busy           <= 1'b1;
`endif
        end else begin
            case (state)
                S_MULT: begin
                    reg_a <= mul_a;
                    reg_q <= mul_q;
                    q_1   <= reg_q[0];
                    count <= count + 6'd1;
                    if (count == 6'd31) begin
                        state          <= S_DONE;
                        data_result    <= mul_q;
                        data_exception <= (mul_a != {32{mul_q[31]}});
                        data_resultRDY <= 1'b1;
                    end
                end
`ifdef MULTDIV_DIV_EN
                S_DIV: begin
                    reg_a <= sum;
                    reg_q <= {reg_q[30:0], ~sum[31]};
                    count <= count + 6'd1;
                    if (count == 6'd31)
                        state <= S_FIX;
                end
                S_FIX: begin
                    state          <= S_DONE;
                    data_result    <= div_zero ? 32'd0 : (neg_q ? sum : reg_q);
                    data_exception <= div_zero | div_ovf;
                    data_resultRDY <= 1'b1;
                end
`endif
                S_DONE: begin
                    state          <= S_IDLE;
                    data_resultRDY <= 1'b0;
                    busy           <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_seq.sv
// tb/tb_multdiv_seq.sv - scoreboard bench for multdiv_seq (define MULTDIV_DIV_EN to match the DUT build)

module tb_multdiv_seq;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          at;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    multdiv_seq dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset && data_resultRDY === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", {31'd0, data_resultRDY}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", data_result, e.res);
                check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                check("rdy_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic start_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                            input logic push, input logic [31:0] er, input logic ee, input int lat);
        @(posedge clock);
        #1;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        if (push) sb.push_back('{er, ee, cyc + lat});
        @(posedge clock);
        #1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (sb.size() != 0 && i < budget) begin
            @(posedge clock);
            i++;
        end
        check("timeout_pending", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clock);
        check("busy_after", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd2;
        data_operandB = 32'd3;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_result", data_result, 32'd0);
        check("reset_exception", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        repeat (3) @(posedge clock);

        start_op(1, 0, 32'd7, 32'hFFFF_FFFA, 1, 32'hFFFF_FFD6, 0, 33);
        repeat (4) @(negedge clock);
        check("busy_during", {31'd0, busy}, 32'd1);
        wait_done(60);

        start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 1, 32'h0, 1, 33);
        wait_done(60);
        start_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, 33);
        wait_done(60);
        start_op(1, 0, 32'h7FFF_FFFF, 32'd1, 1, 32'h7FFF_FFFF, 0, 33);
        wait_done(60);
        start_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd1, 0, 33);
        wait_done(60);
        start_op(1, 0, 32'h8000_0000, 32'd1, 1, 32'h8000_0000, 0, 33);
        wait_done(60);

        start_op(1, 0, 32'd3, 32'd5, 0, 32'd0, 0, 0);
        repeat (8) @(posedge clock);
        start_op(1, 0, 32'd2, 32'd2, 1, 32'd4, 0, 33);
        wait_done(80);

        start_op(1, 0, 32'd3, 32'd5, 0, 32'd0, 0, 0);
        repeat (18) @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        repeat (40) @(posedge clock);

        start_op(1, 1, 32'd6, 32'd3, 1, 32'd18, 0, 33);
        wait_done(60);

`ifdef MULTDIV_DIV_EN
        start_op(0, 1, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, 0, 34);
        wait_done(60);
        start_op(0, 1, 32'd100, 32'd0, 1, 32'd0, 1, 34);
        wait_done(60);
        start_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 1, 34);
        wait_done(60);
        start_op(0, 1, 32'd100, 32'hFFFF_FFF9, 1, 32'hFFFF_FFF2, 0, 34);
        wait_done(60);
        start_op(0, 1, 32'h8000_0000, 32'd2, 1, 32'hC000_0000, 0, 34);
        wait_done(60);
`else
        start_op(0, 1, 32'd100, 32'd5, 1, 32'd0, 1, 1);
        wait_done(20);
`endif

        repeat (5) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
